ysyx_23060042_lsu: RTL and testbench

Load/store unit directly downstream of the execute stage. Takes the ALU-computed effective address, store data, access size and signedness. Performs one word-aligned access on a simple valid/ready memory port with byte-lane masking. Returns sign- or zero-extended load data (the execute stage's mrdata / write-back source) to the next stage through a valid/ready handshake.

---
 rtl/ysyx_23060042_lsu_pkg.sv | 25 ++
 rtl/ysyx_23060042_lsu_align.sv | 43 ++++
 rtl/ysyx_23060042_lsu.sv | 122 ++++++++++++
 tb/tb_ysyx_23060042_lsu.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060042_lsu_pkg.sv
// Shared constants for the load/store unit: FSM state codes, access size
// encodings and the access legality check used at request accept time.
package ysyx_23060042_lsu_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // A request that can never reach memory: conflicting op bits, the unused
    // size code, or a half/word access that straddles its natural boundary.
    function automatic logic is_bad_access(input logic rd, input logic wr,
                                           input logic [1:0] sz, input logic [1:0] off);
        return (rd && wr) || (sz == 2'b11) ||
               ((sz == SZ_H) && off[0]) ||
               ((sz == SZ_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/ysyx_23060042_lsu_align.sv
// Byte-lane steering: store data replication and write mask on the way out,
// load shift and sign/zero extension on the way back.
module ysyx_23060042_lsu_align
    import ysyx_23060042_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        uns,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic [31:0] ld_ext
);

    logic [31:0] w;

    always_comb begin
        wdata  = st_data;
        wmask  = 4'b0000;
        w      = rdata >> {off, 3'b000};
        ld_ext = w;
        case (size)
            SZ_B: begin
                wdata  = {4{st_data[7:0]}};
                wmask  = 4'b0001 << off;
                ld_ext = {{24{w[7] & ~uns}}, w[7:0]};
            end
            SZ_H: begin
                wdata  = {2{st_data[15:0]}};
                wmask  = 4'b0011 << off;
                ld_ext = {{16{w[15] & ~uns}}, w[15:0]};
            end
            SZ_W: begin
                wmask  = 4'b1111;
            end
            default: begin
                wmask  = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060042_lsu.sv
// Load/store unit: accepts one request from execute, runs a single word-aligned
// memory transaction and returns the extended load result to write-back.
module ysyx_23060042_lsu
    import ysyx_23060042_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [1:0]        size,
    input  logic              uns,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ld_data,
    output logic              err,
    output logic              mreq_valid,
    input  logic              mreq_ready,
    output logic [ADDR_W-1:0] mreq_addr,
    output logic              mreq_wen,
    output logic [DATA_W-1:0] mreq_wdata,
    output logic [3:0]        mreq_wmask,
    input  logic              mrsp_valid,
    input  logic [DATA_W-1:0] mrsp_rdata,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Valid never drops and its payload never changes until that transfer.

    state_t            state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_st_data;
    logic [1:0]        r_size;
    logic              r_uns;
    logic              r_wen;
    logic [DATA_W-1:0] r_ld_data;
    logic              r_err;

    logic [DATA_W-1:0] al_wdata;
    logic [3:0]        al_wmask;
    logic [DATA_W-1:0] al_ld_ext;

    ysyx_23060042_lsu_align u_align (
        .size    (r_size),
        .off     (r_addr[1:0]),
        .uns     (r_uns),
        .st_data (r_st_data),
        .rdata   (mrsp_rdata),
        .wdata   (al_wdata),
        .wmask   (al_wmask),
        .ld_ext  (al_ld_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            r_addr    <= '0;
            r_st_data <= '0;
            r_size    <= 2'b00;
            r_uns     <= 1'b0;
            r_wen     <= 1'b0;
            r_ld_data <= '0;
            r_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_addr    <= addr;
                        r_st_data <= st_data;
                        r_size    <= size;
                        r_uns     <= uns;
                        r_ld_data <= '0;
                        r_wen     <= 1'b0;
                        if (!mem_rd && !mem_wr) begin
                            r_err <= 1'b0;
                            state <= ST_DONE;
                        end else if (is_bad_access(mem_rd, mem_wr, size, addr[1:0])) begin
                            r_err <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            r_err <= 1'b0;
                            r_wen <= mem_wr;
                            state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mreq_ready) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Stores also wait for their acknowledge before retiring.
                    if (mrsp_valid) begin
                        r_ld_data <= r_wen ? '0 : al_ld_ext;
                        state     <= ST_DONE;
                    end
                end
                default: begin
                    if (out_ready) state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (state == ST_IDLE);
    assign out_valid  = (state == ST_DONE);
    assign mreq_valid = (state == ST_REQ);
    assign mreq_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign mreq_wen   = r_wen;
    assign mreq_wdata = al_wdata;
    assign mreq_wmask = r_wen ? al_wmask : 4'b0000;
    assign ld_data    = r_ld_data;
    assign err        = r_err;
    assign dbg_state  = state;

endmodule

// File: tb/tb_ysyx_23060042_lsu.sv
// Directed bench for the load/store unit with an auto-responding memory model.
module tb_ysyx_23060042_lsu;
    import ysyx_23060042_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] addr, st_data;
    logic        mem_rd, mem_wr;
    logic [1:0]  size;
    logic        uns;
    logic        out_valid, out_ready;
    logic [31:0] ld_data;
    logic        err;
    logic        mreq_valid, mreq_ready;
    logic [31:0] mreq_addr;
    logic        mreq_wen;
    logic [31:0] mreq_wdata;
    logic [3:0]  mreq_wmask;
    logic        mrsp_valid;
    logic [31:0] mrsp_rdata;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic        resp_en   = 1'b1;
    logic        force_rsp = 1'b0;
    logic [31:0] rsp_word  = 32'h0;
    logic        hs;

    ysyx_23060042_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .addr       (addr),
        .st_data    (st_data),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .size       (size),
        .uns        (uns),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ld_data    (ld_data),
        .err        (err),
        .mreq_valid (mreq_valid),
        .mreq_ready (mreq_ready),
        .mreq_addr  (mreq_addr),
        .mreq_wen   (mreq_wen),
        .mreq_wdata (mreq_wdata),
        .mreq_wmask (mreq_wmask),
        .mrsp_valid (mrsp_valid),
        .mrsp_rdata (mrsp_rdata),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // Memory responds in the cycle after each request handshake.
    always @(posedge clk) begin
        hs = resp_en && mreq_valid && mreq_ready;
        #1;
        mrsp_valid = hs || force_rsp;
        mrsp_rdata = rsp_word;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic rd,
                         input logic wr, input logic [1:0] sz, input logic u);
        addr = a; st_data = d; mem_rd = rd; mem_wr = wr; size = sz; uns = u;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    // lat counts edges from the accept edge (1) to the edge that raised out_valid.
    task automatic wait_out(output int lat, output logic seen, output logic [31:0] c_addr,
                            output logic [31:0] c_wdata, output logic c_wen,
                            output logic [3:0] c_wmask);
        lat = 1; seen = 1'b0; c_addr = '0; c_wdata = '0; c_wen = 1'b0; c_wmask = '0;
        while (!out_valid && lat < 40) begin
            if (mreq_valid && !seen) begin
                seen = 1'b1; c_addr = mreq_addr; c_wdata = mreq_wdata;
                c_wen = mreq_wen; c_wmask = mreq_wmask;
            end
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        checks++; if ({out_valid, mreq_valid, mreq_wen, err} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b exp 0000", {out_valid, mreq_valid, mreq_wen, err}); end
        checks++; if (ld_data !== 32'h0) begin errors++; $display("FAIL rst_ld_data got %h exp 0", ld_data); end
        checks++; if ({mreq_addr, mreq_wdata, mreq_wmask} !== 68'h0) begin errors++; $display("FAIL rst_mreq got %h/%h/%b exp 0", mreq_addr, mreq_wdata, mreq_wmask); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d exp %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_lw();
        int lat; logic seen, c_wen; logic [31:0] c_addr, c_wdata; logic [3:0] c_wmask;
        rsp_word = 32'hDEADBEEF;
        issue(32'h80000008, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0);
        wait_out(lat, seen, c_addr, c_wdata, c_wen, c_wmask);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL lw_req_seen got %b exp 1", seen); end
        checks++; if (c_addr !== 32'h80000008) begin errors++; $display("FAIL lw_mreq_addr got %h exp 80000008", c_addr); end
        checks++; if ({c_wen, c_wmask} !== 5'b0_0000) begin errors++; $display("FAIL lw_wen_wmask got %b exp 00000", {c_wen, c_wmask}); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency got %0d exp 3", lat); end
        checks++; if (ld_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_ld_data got %h exp deadbeef", ld_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", err); end
        tick();
    endtask

    task automatic test_load_extend();
        logic [31:0] v_addr[5] = '{32'h80000003, 32'h80000003, 32'h80000002, 32'h80000002, 32'h80000000};
        logic [1:0]  v_sz[5]   = '{SZ_B, SZ_B, SZ_H, SZ_H, SZ_B};
        logic        v_uns[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] v_rd[5]   = '{32'h80123456, 32'h80123456, 32'h80011234, 32'h80011234, 32'h1234567F};
        logic [31:0] v_exp[5]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'h0000007F};
        int lat; logic seen, c_wen; logic [31:0] c_addr, c_wdata; logic [3:0] c_wmask;
        for (int i = 0; i < 5; i++) begin
            rsp_word = v_rd[i];
            issue(v_addr[i], 32'h0, 1'b1, 1'b0, v_sz[i], v_uns[i]);
            wait_out(lat, seen, c_addr, c_wdata, c_wen, c_wmask);
            checks++; if (ld_data !== v_exp[i]) begin errors++; $display("FAIL load_ext[%0d] got %h exp %h", i, ld_data, v_exp[i]); end
            checks++; if (c_addr !== {v_addr[i][31:2], 2'b00}) begin errors++; $display("FAIL load_addr[%0d] got %h exp %h", i, c_addr, {v_addr[i][31:2], 2'b00}); end
            tick();
        end
    endtask

    task automatic test_store();
        logic [31:0] v_addr[3]  = '{32'h80000001, 32'h80000002, 32'h80000004};
        logic [31:0] v_d[3]     = '{32'h000000AB, 32'h1234CDEF, 32'h11223344};
        logic [1:0]  v_sz[3]    = '{SZ_B, SZ_H, SZ_W};
        logic [31:0] v_wd[3]    = '{32'hABABABAB, 32'hCDEFCDEF, 32'h11223344};
        logic [3:0]  v_wm[3]    = '{4'b0010, 4'b1100, 4'b1111};
        logic [31:0] v_ma[3]    = '{32'h80000000, 32'h80000000, 32'h80000004};
        int lat; logic seen, c_wen; logic [31:0] c_addr, c_wdata; logic [3:0] c_wmask;
        rsp_word = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            issue(v_addr[i], v_d[i], 1'b0, 1'b1, v_sz[i], 1'b0);
            wait_out(lat, seen, c_addr, c_wdata, c_wen, c_wmask);
            checks++; if (c_wen !== 1'b1) begin errors++; $display("FAIL st_wen[%0d] got %b exp 1", i, c_wen); end
            checks++; if (c_wdata !== v_wd[i]) begin errors++; $display("FAIL st_wdata[%0d] got %h exp %h", i, c_wdata, v_wd[i]); end
            checks++; if (c_wmask !== v_wm[i]) begin errors++; $display("FAIL st_wmask[%0d] got %b exp %b", i, c_wmask, v_wm[i]); end
            checks++; if (c_addr !== v_ma[i]) begin errors++; $display("FAIL st_addr[%0d] got %h exp %h", i, c_addr, v_ma[i]); end
            checks++; if ({ld_data, err, lat[3:0]} !== {32'h0, 1'b0, 4'd3}) begin errors++; $display("FAIL st_done[%0d] got ld %h err %b lat %0d exp 0/0/3", i, ld_data, err, lat); end
            tick();
        end
    endtask

    task automatic test_err_and_nop();
        logic [31:0] v_addr[6] = '{32'h80000002, 32'h80000000, 32'h80000001, 32'h80000000, 32'h80000000, 32'h80000003};
        logic        v_rd[6]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        v_wr[6]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0]  v_sz[6]   = '{SZ_W, 2'b11, SZ_H, SZ_W, SZ_W, SZ_W};
        logic        v_err[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int lat; logic seen, c_wen; logic [31:0] c_addr, c_wdata; logic [3:0] c_wmask;
        for (int i = 0; i < 6; i++) begin
            // in_ready must be back one cycle after the previous DONE handshake
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, in_ready); end
            issue(v_addr[i], 32'hCAFEF00D, v_rd[i], v_wr[i], v_sz[i], 1'b0);
            wait_out(lat, seen, c_addr, c_wdata, c_wen, c_wmask);
            checks++; if (seen !== 1'b0) begin errors++; $display("FAIL err_no_req[%0d] got %b exp 0", i, seen); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL err_latency[%0d] got %0d exp 1", i, lat); end
            checks++; if (err !== v_err[i]) begin errors++; $display("FAIL err_flag[%0d] got %b exp %b", i, err, v_err[i]); end
            checks++; if (ld_data !== 32'h0) begin errors++; $display("FAIL err_ld_data[%0d] got %h exp 0", i, ld_data); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int lat; logic seen, c_wen; logic [31:0] c_addr, c_wdata; logic [3:0] c_wmask;
        rsp_word = 32'h0BADF00D;
        mreq_ready = 1'b0;
        out_ready  = 1'b0;
        issue(32'h8000000C, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++; if ({mreq_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL bp_req_hold[%0d] valid/in_ready got %b exp 10", i, {mreq_valid, in_ready}); end
            checks++; if ({mreq_addr, mreq_wen, mreq_wmask} !== {32'h8000000C, 1'b0, 4'b0000}) begin errors++; $display("FAIL bp_req_fields[%0d] got %h/%b/%b", i, mreq_addr, mreq_wen, mreq_wmask); end
            tick();
        end
        mreq_ready = 1'b1;
        wait_out(lat, seen, c_addr, c_wdata, c_wen, c_wmask);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b exp 1", out_valid); end
        for (int i = 0; i < 4; i++) begin
            checks++; if ({out_valid, in_ready, err} !== 3'b100) begin errors++; $display("FAIL bp_done_hold[%0d] got %b exp 100", i, {out_valid, in_ready, err}); end
            checks++; if (ld_data !== 32'h0BADF00D) begin errors++; $display("FAIL bp_ld_data[%0d] got %h exp 0badf00d", i, ld_data); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got %b exp 01", {out_valid, in_ready}); end
    endtask

    task automatic test_reset_mid();
        resp_en  = 1'b0;
        rsp_word = 32'h12345678;
        issue(32'h80000010, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0);
        tick();
        checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL rm_in_wait got %0d exp %0d", dbg_state, ST_WAIT); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({in_ready, out_valid, mreq_valid, mreq_wen, err} !== 5'b10000) begin errors++; $display("FAIL rm_flags got %b exp 10000", {in_ready, out_valid, mreq_valid, mreq_wen, err}); end
        checks++; if ({ld_data, mreq_addr, mreq_wdata, mreq_wmask} !== 100'h0) begin errors++; $display("FAIL rm_data got %h/%h/%h/%b exp 0", ld_data, mreq_addr, mreq_wdata, mreq_wmask); end
        force_rsp = 1'b1;
        tick();
        tick();
        force_rsp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({out_valid, in_ready, dbg_state} !== {2'b01, ST_IDLE}) begin errors++; $display("FAIL rm_stray_rsp[%0d] got %b exp 0100", i, {out_valid, in_ready, dbg_state}); end
            tick();
        end
        resp_en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; addr = '0; st_data = '0; mem_rd = 1'b0; mem_wr = 1'b0;
        size = SZ_W; uns = 1'b0; out_ready = 1'b1; mreq_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_lw();
        test_load_extend();
        test_store();
        test_err_and_nop();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
